soqpsk_lut_sequencer: RTL

Transmit-side sequencer that consumes the SOQPSK modulator's serial bit stream and reads the SOQPSK pulse-shape ROM (512 × 14, 2-cycle read latency). It keeps the bit-history and symbol-parity state that forms the ROM address, steps the sample phase at the sample-rate strobe, and realigns ROM output data with a valid flag. It sits between the framer's bit FIFO and the DAC sample path, so it is the reader side of the pulse-shape LUT.

---
 rtl/soqpsk_lut_sequencer_pkg.sv | 38 +++
 rtl/soqpsk_lut_sequencer_if.sv | 32 +++
 rtl/soqpsk_lut_sequencer_lat_pipe.sv | 49 ++++
 rtl/soqpsk_lut_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/soqpsk_lut_sequencer_pkg.sv
// Shared types and constants for the SOQPSK pulse-shape LUT sequencer.
// ROM address layout is {hist[3:0], parity, phase[3:0]}.
package soqpsk_pkg;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 14;
  localparam int SPS     = 16;
  localparam int ROM_LAT = 2;

  localparam int PHASE_W = $clog2(SPS);
  localparam int HIST_W  = 4;
  localparam int UF_W    = 8;

  localparam int PHASE_LSB  = 0;
  localparam int PARITY_BIT = 4;
  localparam int HIST_LSB   = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_PEND = 2'd2
  } state_t;

  // Pack the bit history, symbol parity and sample phase into a LUT address.
  function automatic logic [ADDR_W-1:0] make_addr(
    input logic [HIST_W-1:0]  hist,
    input logic               parity,
    input logic [PHASE_W-1:0] phase
  );
    logic [ADDR_W-1:0] a;
    a = '0;
    a[HIST_LSB +: HIST_W]   = hist;
    a[PARITY_BIT]           = parity;
    a[PHASE_LSB +: PHASE_W] = phase;
    return a;
  endfunction

endpackage

// File: rtl/soqpsk_lut_sequencer_if.sv
// Bundle of control, bit-stream, ROM and sample-stream signals around the
// sequencer. master = the sequencer itself, slave = its surroundings.
interface soqpsk_lut_sequencer_if;
  import soqpsk_pkg::*;

  logic              sample_en;
  logic              start;
  logic              stop;
  logic              in_bit;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] out_sample;
  logic              out_valid;
  logic              out_sym_start;
  logic [UF_W-1:0]   underflow_cnt;
  logic              busy;

  modport master (
    input  sample_en, start, stop, in_bit, in_valid, rom_q,
    output in_ready, rom_addr, out_sample, out_valid, out_sym_start,
           underflow_cnt, busy
  );

  modport slave (
    output sample_en, start, stop, in_bit, in_valid, rom_q,
    input  in_ready, rom_addr, out_sample, out_valid, out_sym_start,
           underflow_cnt, busy
  );

endinterface

// File: rtl/soqpsk_lut_sequencer_lat_pipe.sv
// Fixed-depth shift register that carries per-sample flags alongside the
// ROM read so they line up with the returned data.
module soqpsk_lat_pipe #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             occupied
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Each stage loads its predecessor; stage 0 loads the pipe input.
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // One register per stage, cleared on reset so nothing stale escapes.
      always_ff @(posedge clock) begin
        if (reset) begin
          stage_q[gi] <= '0;
        end else begin
          stage_q[gi] <= stage_d[gi];
        end
      end
    end
  endgenerate

  // Any flag still in flight means the pipe has not drained yet.
  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied = occupied | (|stage_q[i]);
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/soqpsk_lut_sequencer.sv
// SOQPSK pulse-shape LUT reader: tracks bit history and symbol parity,
// steps the sample phase on each sample strobe, and re-aligns ROM data
// with valid/symbol-start flags.
module soqpsk_lut_sequencer
  import soqpsk_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  soqpsk_lut_sequencer_if.master bus
);

  // addr register + ROM latency
  localparam int                 PIPE_DEPTH = ROM_LAT + 1;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SPS - 1);
  localparam logic [UF_W-1:0]    UF_MAX     = '1;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic                parity_q, parity_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [UF_W-1:0]     uf_cnt_q, uf_cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;

  logic                step;
  logic                boundary;
  logic                take_bit;
  logic [1:0]          pipe_din;
  logic [1:0]          pipe_dout;
  logic                pipe_occupied;

  // Decode the sample strobe into a step, a symbol boundary and a bit take.
  always_comb begin
    step     = (state_q != ST_IDLE) && bus.sample_en;
    boundary = step && (phase_q == LAST_PHASE);
    // Only RUN consumes a bit; the STOP_PEND boundary just ends the burst.
    take_bit = boundary && (state_q == ST_RUN);
    pipe_din = {step && (phase_q == '0), step};
  end

  // Next-state logic for the control FSM, address, history and hold register.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hist_d     = hist_q;
    parity_d   = parity_q;
    rom_addr_d = rom_addr_q;
    uf_cnt_d   = uf_cnt_q;
    hold_d     = hold_q;

    case (state_q)
      ST_IDLE: begin
        phase_d    = '0;
        hist_d     = '0;
        parity_d   = 1'b0;
        rom_addr_d = '0;
        if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_STOP_PEND: begin
        if (step) begin
          rom_addr_d = make_addr(hist_q, parity_q, phase_q);
          phase_d    = phase_q + 1'b1;
        end
        if (take_bit) begin
          // A missing bit is replaced by a 0 fill and counted.
          hist_d   = {hist_q[HIST_W-2:0], bus.in_valid & bus.in_bit};
          parity_d = ~parity_q;
          if (!bus.in_valid && (uf_cnt_q != UF_MAX)) begin
            uf_cnt_d = uf_cnt_q + 1'b1;
          end
        end
        // A stop coinciding with a boundary still lets that boundary
        // consume its bit; the burst ends at the following boundary.
        if ((state_q == ST_RUN) && bus.stop) begin
          state_d = ST_STOP_PEND;
        end
        if ((state_q == ST_STOP_PEND) && boundary) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Keep the last sample between strobes; zero it once idle and drained.
    if (pipe_dout[0]) begin
      hold_d = bus.rom_q;
    end else if ((state_q == ST_IDLE) && !pipe_occupied) begin
      hold_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      hist_q     <= '0;
      parity_q   <= 1'b0;
      rom_addr_q <= '0;
      uf_cnt_q   <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hist_q     <= hist_d;
      parity_q   <= parity_d;
      rom_addr_q <= rom_addr_d;
      uf_cnt_q   <= uf_cnt_d;
      hold_q     <= hold_d;
    end
  end

  soqpsk_lat_pipe #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (2)
  ) u_lat_pipe (
    .clock    (clock),
    .reset    (reset),
    .din      (pipe_din),
    .dout     (pipe_dout),
    .occupied (pipe_occupied)
  );

  // in_ready is a same-cycle acknowledge of the boundary bit; suppressed
  // during reset so a reset cycle never swallows upstream data.
  assign bus.in_ready      = take_bit & bus.in_valid & ~reset;
  assign bus.rom_addr      = rom_addr_q;
  assign bus.out_valid     = pipe_dout[0];
  assign bus.out_sym_start = pipe_dout[1];
  // ROM data arrives in the same cycle as the delayed valid flag.
  assign bus.out_sample    = pipe_dout[0] ? bus.rom_q : hold_q;
  assign bus.underflow_cnt = uf_cnt_q;
  assign bus.busy          = (state_q != ST_IDLE);

endmodule
